// File: rtl/mem_port_ctrl.sv
// Byte-wide single-port RAM controller serving IF fetches and MEM loads/stores.
// Define IF_ABORT_EN to let a MEM request abort an in-flight IF read.
module mem_port_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  output logic              if_done,
  output logic [31:0]       if_data,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic              own_mem, own_mem_nx;
  logic              we, we_nx;
  logic              quiet, quiet_nx;
  logic [2:0]        n, n_nx;
  logic [2:0]        k, k_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [31:0]       data_q, data_nx;
  logic [ADDR_W-1:0] a_c;
  logic [7:0]        dout_c;
  logic              wr_c;
  logic              done_c;
  logic [2:0]        msz;
  logic [1:0]        kb;

  assign msz = (mem_size == 2'd0) ? 3'd1 :
               (mem_size == 2'd1) ? 3'd2 : 3'd4;
  assign kb  = 2'(k - 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      own_mem <= 1'b0;
      we      <= 1'b0;
      quiet   <= 1'b0;
      n       <= '0;
      k       <= '0;
      base    <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_nx;
      own_mem <= own_mem_nx;
      we      <= we_nx;
      quiet   <= quiet_nx;
      n       <= n_nx;
      k       <= k_nx;
      base    <= base_nx;
      data_q  <= data_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    own_mem_nx = own_mem;
    we_nx      = we;
    quiet_nx   = quiet;
    n_nx       = n;
    k_nx       = k;
    base_nx    = base;
    data_nx    = data_q;
    a_c        = '0;
    dout_c     = '0;
    wr_c       = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        quiet_nx = 1'b0;
        if (mem_req) begin
          own_mem_nx = 1'b1;
          we_nx      = mem_we;
          n_nx       = msz;
          k_nx       = 3'd1;
          base_nx    = mem_addr;
          data_nx    = mem_we ? mem_wdata : '0;
          a_c        = mem_addr;
          state_nx   = BUSY;
          if (mem_we) begin
            wr_c   = 1'b1;
            dout_c = mem_wdata[7:0];
            if (msz == 3'd1) state_nx = DONE;
          end
        end else if (if_req) begin
          own_mem_nx = 1'b0;
          we_nx      = 1'b0;
          n_nx       = 3'd4;
          k_nx       = 3'd1;
          base_nx    = if_addr;
          data_nx    = '0;
          a_c        = if_addr;
          state_nx   = BUSY;
        end
      end
      BUSY: begin
        if (!own_mem && !if_req) begin
          state_nx = IDLE;
        end
`ifdef IF_ABORT_EN
        else if (!own_mem && mem_req) begin
          state_nx = DONE;
          quiet_nx = 1'b1;
        end
`endif
        else if (we) begin
          a_c    = base + ADDR_W'(k);
          wr_c   = 1'b1;
          dout_c = data_q[{k[1:0], 3'b000} +: 8];
          if (k == n - 3'd1) state_nx = DONE;
          else k_nx = k + 3'd1;
        end else begin
          // ram_din now holds the byte addressed one cycle earlier
          data_nx[{kb, 3'b000} +: 8] = ram_din;
          if (k < n) begin
            a_c  = base + ADDR_W'(k);
            k_nx = k + 3'd1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        done_c   = ~quiet;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ram_a     = reset ? a_c : '0;
  assign ram_dout  = reset ? dout_c : '0;
  assign ram_wr    = reset & wr_c;
  assign if_done   = reset & done_c & ~own_mem;
  assign mem_done  = reset & done_c & own_mem;
  assign if_data   = if_done ? data_q : '0;
  assign mem_rdata = (mem_done & ~we) ? data_q : '0;
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Single-port memory controller that serves the instruction-fetch (IF) stage and the MEM stage over one byte-wide synchronous RAM port. It is the source of the `stall_if` and `stall_mem` requests that feed the pipeline stall controller. It holds each requesting stage stalled until its multi-byte access completes, then returns the assembled data with a one-cycle done pulse.

## Interface
- `ADDR_W`, 32, address width of both stage requests and the RAM port.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: IF requests a 4-byte instruction read at `if_addr`.
- `if_addr` in ADDR_W: instruction address.
- `mem_req` in 1: MEM requests a load or store.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_size` in 2: byte count; 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = treated as 4 B.
- `mem_addr` in ADDR_W: data address.
- `mem_wdata` in 32: store data; byte k is `mem_wdata[8k+7:8k]`.
- `ram_din` in 8: RAM read data; valid one cycle after its address.
- `ram_a` out ADDR_W: RAM address.
- `ram_dout` out 8: RAM write data.
- `ram_wr` out 1: RAM write strobe.
- `if_done` out 1: one-cycle pulse; `if_data` valid.
- `if_data` out 32: little-endian instruction.
- `mem_done` out 1: one-cycle pulse; `mem_rdata` valid for loads.
- `mem_rdata` out 32: little-endian load data, zero-extended. The MEM stage sign-extends.
- `stall_if` out 1: combinational, `if_req & ~if_done`.
- `stall_mem` out 1: combinational, `mem_req & ~mem_done`.

## Operation
- States are IDLE, BUSY and DONE. Registers: `owner` (IF/MEM), `we`, `n` (byte count N), `k` (issue index), base address, 32-bit assembly buffer.
- IDLE:
  - If `mem_req`, accept MEM; MEM has priority when both requests are high.
  - Else if `if_req`, accept IF with N = 4.
  - The acceptance cycle drives `ram_a` = addr, combinationally from the request. For a store it also drives `ram_wr` = 1 and `ram_dout` = byte 0.
  - Go to BUSY with k = 1. Exception: a 1-byte store goes directly to DONE.
- BUSY, read:
  - While k < N, drive `ram_a` = base + k and increment k.
  - `ram_din` captured in cycle A+j+1 is stored as byte j.
  - After byte N-1 is captured, go to DONE.
- BUSY, write:
  - Drive `ram_a` = base + k, `ram_wr` = 1 and `ram_dout` = byte k.
  - After k = N-1, go to DONE.
- DONE:
  - Pulse the owner's done output for one cycle with its data.
  - Drive `ram_wr` = 0 and go to IDLE.
  - The same request, still high in this cycle, is not re-accepted.
- Addresses use modulo 2^ADDR_W arithmetic; base + k wraps silently.
- Once accepted, a transaction is never preempted by a later `mem_req`, unless enabled under Configuration.
- If `if_req` drops during an IF transaction (branch flush), go to IDLE the next cycle with no `if_done`.
- A MEM transaction always completes. `mem_req` must stay high until `mem_done`.
- Request inputs are sampled only in IDLE. Changes to address or data while BUSY are ignored.

## Timing
- The acceptance cycle is A.
- Read of N bytes: bytes arrive in cycles A+1..A+N; done in cycle A+N+1.
  - IF latency: done in cycle A+5.
- Write of N bytes: `ram_wr` high in cycles A..A+N-1; done in cycle A+N.
- The next acceptance is possible in the cycle after done.
- Reset values while `reset` = 0: state IDLE, `ram_a` = 0, `ram_dout` = 0, `ram_wr` = 0, `if_done` = 0, `mem_done` = 0, `if_data` = 0, `mem_rdata` = 0.
- Reset asserted mid-transaction abandons it immediately. No done is issued. A partial write may remain in RAM.

## Configuration
- `IF_ABORT_EN`, defined:
  - While BUSY on an IF read, a high `mem_req` aborts the IF.
  - The controller goes to IDLE in the next cycle and accepts MEM in the cycle after that.
  - IF is refetched from byte 0 later.
- `IF_ABORT_EN`, undefined: the IF completes first, and MEM waits.

## Test plan
- IF read at `0x0000_0100`, RAM bytes 13 05 00 00 -> `ram_a` 0x100..0x103 in A..A+3; `if_done` in A+5 with `if_data` = 0x0000_0513; `stall_if` = 1 in A..A+4, 0 in A+5.
- Word store, `mem_addr` = 0x200, `mem_wdata` = 0xDEAD_BEEF -> `ram_wr` = 1 in A..A+3 with bytes EF BE AD DE at 0x200..0x203; `mem_done` in A+4.
- `if_req` and `mem_req` high together, 1-byte load at 0x10 returning 0x80 -> MEM served first; `mem_done` in A+2 with `mem_rdata` = 0x0000_0080; IF accepted in A+3.
- `mem_req` rising in A+1 of an IF -> without `IF_ABORT_EN`, `if_done` in A+5 and MEM accepted in A+6; with it, no `if_done` and MEM accepted in A+3.
- Halfword load at 0xFFFF_FFFF -> addresses 0xFFFF_FFFF then 0x0000_0000; `mem_done` in A+3.
- `reset` pulled low in A+2 of a word store -> outputs zero immediately, state IDLE, no `mem_done`.
